dsec_stream_ctrl: RTL and testbench

Parametrised stream controller for the data-stream compression/encryption device. It generalises the fixed three-key, single-register top-level control: it loads NUM_KEYS keys of DATA_W bits, gates data beats into the compression/encryption core with a valid/ready handshake, and buffers core results in a DEPTH-entry output FIFO. It also reports sticky error codes on the output channel. It sits between the host port and the processing core.

---
 rtl/dsec_pkg.sv | 23 ++
 rtl/dsec_out_fifo.sv | 71 +++++++
 rtl/dsec_stream_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dsec_stream_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsec_pkg.sv
// Shared types and constants for the data-stream compression/encryption controller.
package dsec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_RUN,
        ST_DRAIN,
        ST_ERR
    } state_t;

    localparam logic [7:0] ERR_NOKEY     = 8'hE1;
    localparam logic [7:0] ERR_OVERFLOW  = 8'hE2;
    localparam logic [7:0] ERR_KEY_ABORT = 8'hE3;

    // Widest data word the error-word builder supports; callers truncate to DATA_W.
    localparam int ERR_WORD_W = 256;

    function automatic logic [ERR_WORD_W-1:0] err_word(input logic [7:0] code);
        return {{(ERR_WORD_W-8){1'b0}}, code};
    endfunction

endpackage

// File: rtl/dsec_out_fifo.sv
// Output FIFO for core results: registered head word, occupancy count, flush.
module dsec_out_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] head_q, head_nxt;
    logic              do_push, do_pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = head_q;

    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        rd_nxt  = rd_ptr + AW'(do_pop);
        wr_nxt  = wr_ptr + AW'(do_push);
        cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);
        // The next head is either already stored or is the word being written this cycle.
        if (cnt_nxt == '0)
            head_nxt = '0;
        else if (do_push && (rd_nxt == wr_ptr))
            head_nxt = wdata;
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            cnt    <= cnt_nxt;
            head_q <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dsec_stream_ctrl.sv
// Stream controller: key loading, host-to-core beat gating, output buffering and sticky errors.
module dsec_stream_ctrl
    import dsec_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int NUM_KEYS     = 3,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         err_clr,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         key_config,
    input  logic                         in_valid,
    output logic                         rdy,
    output logic [DATA_W-1:0]            data_out,
    output logic                         out_valid,
    input  logic                         out_rcvd,
    output logic                         error,
    output logic [NUM_KEYS*DATA_W-1:0]   keys,
    output logic                         keys_valid,
    output logic [DATA_W-1:0]            core_data,
    output logic                         core_valid,
    input  logic                         core_rdy,
    input  logic                         core_idle,
    input  logic [DATA_W-1:0]            core_out,
    input  logic                         core_out_valid,
    output logic                         core_stall
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    state_t                     state, state_nxt;
    logic [7:0]                 code, code_nxt;
    logic [IDX_W-1:0]           idx;
    logic [NUM_KEYS*DATA_W-1:0] key_q;
    logic                       kv;
    logic                       accept, in_err;
    logic                       key_we, kv_set, kv_clr;
    logic [IDX_W-1:0]           key_sel;
    logic                       fifo_push, fifo_pop, fifo_flush;
    logic                       fifo_full, fifo_empty, overflow;
    logic [CW-1:0]              fifo_count;
    logic [DATA_W-1:0]          fifo_head;

    assign in_err     = (state == ST_ERR);
    assign accept     = in_valid && rdy;
    assign fifo_pop   = !fifo_empty && out_rcvd && !in_err;
    assign fifo_push  = core_out_valid && !in_err;
    assign overflow   = fifo_push && fifo_full && !fifo_pop;
    assign fifo_flush = in_err && err_clr;

    dsec_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (core_out),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            code  <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (key_config) begin
                        state_nxt = (NUM_KEYS == 1) ? ST_RUN : ST_KEY;
                    end else begin
                        state_nxt = ST_ERR;
                        code_nxt  = ERR_NOKEY;
                    end
                end
            end
            ST_KEY: begin
                if (accept) begin
                    if (key_config) begin
                        state_nxt = ST_ERR;
                        code_nxt  = ERR_KEY_ABORT;
                    end else if (idx == LAST_IDX) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid && key_config)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (accept)
                    state_nxt = (NUM_KEYS == 1) ? ST_RUN : ST_KEY;
            end
            ST_ERR: begin
                if (err_clr)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A protocol error raised in the same cycle outranks a FIFO overflow.
        if (overflow && (state_nxt != ST_ERR)) begin
            state_nxt = ST_ERR;
            code_nxt  = ERR_OVERFLOW;
        end
    end

    always_comb begin
        rdy        = 1'b0;
        core_valid = 1'b0;
        key_we     = 1'b0;
        key_sel    = '0;
        kv_set     = 1'b0;
        kv_clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (in_valid && key_config) begin
                    key_we = 1'b1;
                    kv_set = (NUM_KEYS == 1);
                end
            end
            ST_KEY: begin
                rdy = 1'b1;
                if (in_valid && !key_config) begin
                    key_we  = 1'b1;
                    key_sel = idx;
                    kv_set  = (idx == LAST_IDX);
                end
            end
            ST_RUN: begin
                rdy        = core_rdy && !key_config;
                core_valid = in_valid && core_rdy && !key_config;
            end
            ST_DRAIN: begin
                rdy = core_idle && fifo_empty;
                if (in_valid && core_idle && fifo_empty) begin
                    key_we = 1'b1;
                    if (NUM_KEYS == 1)
                        kv_set = 1'b1;
                    else
                        kv_clr = 1'b1;
                end
            end
            ST_ERR: begin
                kv_clr = err_clr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
            idx   <= '0;
            kv    <= 1'b0;
        end else begin
            if (key_we) begin
                key_q[key_sel*DATA_W +: DATA_W] <= data_in;
                idx <= (key_sel == LAST_IDX) ? '0 : key_sel + IDX_W'(1);
            end
            if (kv_clr)
                kv <= 1'b0;
            else if (kv_set)
                kv <= 1'b1;
        end
    end

    assign keys       = key_q;
    assign keys_valid = kv;
    assign error      = in_err;
    assign core_data  = data_in;
    assign out_valid  = in_err || !fifo_empty;
    assign data_out   = in_err ? DATA_W'(err_word(code)) : fifo_head;
    assign core_stall = (CW'(DEPTH) - fifo_count) <= CW'(STALL_MARGIN);

endmodule

// File: tb/tb_dsec_stream_ctrl.sv
// Randomised and directed bench for dsec_stream_ctrl against a queue-based reference model.
module tb_dsec_stream_ctrl;

    localparam int DW = 64;
    localparam int NK = 3;
    localparam int DP = 8;
    localparam int SM = 2;

    logic              clk = 1'b0;
    logic              rst, err_clr, key_config, in_valid, out_rcvd;
    logic              core_rdy, core_idle, core_out_valid;
    logic [DW-1:0]     data_in, core_out, data_out, core_data;
    logic              rdy, out_valid, error, keys_valid, core_valid, core_stall;
    logic [NK*DW-1:0]  keys;

    always #5 clk = ~clk;

    dsec_stream_ctrl #(
        .DATA_W       (DW),
        .NUM_KEYS     (NK),
        .DEPTH        (DP),
        .STALL_MARGIN (SM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .err_clr        (err_clr),
        .data_in        (data_in),
        .key_config     (key_config),
        .in_valid       (in_valid),
        .rdy            (rdy),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_rcvd       (out_rcvd),
        .error          (error),
        .keys           (keys),
        .keys_valid     (keys_valid),
        .core_data      (core_data),
        .core_valid     (core_valid),
        .core_rdy       (core_rdy),
        .core_idle      (core_idle),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .core_stall     (core_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phase of the key/stream protocol, error flag, key array, result queue.
    typedef enum {M_WAIT_KEY, M_LOADING, M_STREAM, M_REKEY} mphase_t;
    mphase_t       ph;
    bit            m_err;
    logic [7:0]    m_code;
    int            m_loaded;
    logic [DW-1:0] m_key [NK];
    bit            m_kv;
    logic [DW-1:0] q [$];

    function automatic bit exp_rdy();
        if (m_err) return 1'b0;
        case (ph)
            M_STREAM: return core_rdy && !key_config;
            M_REKEY:  return core_idle && (q.size() == 0);
            default:  return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        ph       = M_WAIT_KEY;
        m_err    = 1'b0;
        m_code   = '0;
        m_loaded = 0;
        m_kv     = 1'b0;
        for (int k = 0; k < NK; k++) m_key[k] = '0;
        q.delete();
    endtask

    task automatic compare_all();
        logic [NK*DW-1:0] ek;
        logic [DW-1:0]    ed;
        for (int k = 0; k < NK; k++) ek[k*DW +: DW] = m_key[k];
        if (m_err)           ed = {{(DW-8){1'b0}}, m_code};
        else if (q.size())   ed = q[0];
        else                 ed = '0;
        chk("rdy",        256'(rdy),        256'(exp_rdy()));
        chk("core_valid", 256'(core_valid), 256'(!m_err && ph == M_STREAM && in_valid && core_rdy && !key_config));
        chk("core_data",  256'(core_data),  256'(data_in));
        chk("out_valid",  256'(out_valid),  256'(m_err || q.size() > 0));
        chk("data_out",   256'(data_out),   256'(ed));
        chk("error",      256'(error),      256'(m_err));
        chk("keys_valid", 256'(keys_valid), 256'(m_kv));
        chk("keys",       256'(keys),       256'(ek));
        chk("core_stall", 256'(core_stall), 256'((DP - q.size()) <= SM));
    endtask

    task automatic model_step();
        bit         acc, pop, new_err;
        logic [7:0] ncode;
        int         n;
        n       = q.size();
        acc     = in_valid && exp_rdy();
        new_err = 1'b0;
        ncode   = '0;
        if (m_err) begin
            if (err_clr) begin
                m_err = 1'b0;
                m_kv  = 1'b0;
                ph    = M_WAIT_KEY;
                q.delete();
            end
            return;
        end
        case (ph)
            M_WAIT_KEY: if (acc) begin
                if (key_config) begin
                    m_key[0] = data_in;
                    m_loaded = 1;
                    ph       = M_LOADING;
                end else begin
                    new_err = 1'b1;
                    ncode   = 8'hE1;
                end
            end
            M_LOADING: if (acc) begin
                if (key_config) begin
                    new_err = 1'b1;
                    ncode   = 8'hE3;
                end else begin
                    m_key[m_loaded] = data_in;
                    m_loaded++;
                    if (m_loaded == NK) begin
                        m_kv = 1'b1;
                        ph   = M_STREAM;
                    end
                end
            end
            M_STREAM: if (in_valid && key_config) ph = M_REKEY;
            M_REKEY: if (acc) begin
                m_key[0] = data_in;
                m_kv     = 1'b0;
                m_loaded = 1;
                ph       = M_LOADING;
            end
            default: ;
        endcase
        pop = (n > 0) && out_rcvd;
        if (pop) void'(q.pop_front());
        if (core_out_valid && (n < DP || pop)) q.push_back(core_out);
        if (core_out_valid && n == DP && !pop && !new_err) begin
            new_err = 1'b1;
            ncode   = 8'hE2;
        end
        if (new_err) begin
            m_err  = 1'b1;
            m_code = ncode;
        end
    endtask

    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        in_valid       = 1'b0;
        key_config     = 1'b0;
        err_clr        = 1'b0;
        core_out_valid = 1'b0;
        out_rcvd       = 1'b0;
        core_rdy       = 1'b1;
        core_idle      = 1'b1;
    endtask

    task automatic beat(input logic kc, input logic [DW-1:0] d);
        in_valid   = 1'b1;
        key_config = kc;
        data_in    = d;
        tick();
    endtask

    task automatic rand_inputs(input int rcvd_pct, input int cov_pct);
        in_valid = ($urandom_range(0, 99) < 60);
        if (ph == M_WAIT_KEY && !m_err) key_config = ($urandom_range(0, 99) < 90);
        else                            key_config = ($urandom_range(0, 99) < 4);
        data_in        = {$urandom, $urandom};
        err_clr        = m_err ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
        out_rcvd       = ($urandom_range(0, 99) < rcvd_pct);
        core_out_valid = ($urandom_range(0, 99) < cov_pct);
        core_out       = {$urandom, $urandom};
        core_rdy       = ($urandom_range(0, 99) < 80);
        core_idle      = ($urandom_range(0, 99) < 70);
    endtask

    logic [DW-1:0] ka, kb, kc;

    initial begin
        quiet();
        data_in  = '0;
        core_out = '0;
        rst      = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Key load A, B, C.
        ka = 64'hA1A1_0000_0000_000A;
        kb = 64'hB2B2_0000_0000_000B;
        kc = 64'hC3C3_0000_0000_000C;
        beat(1'b1, ka);
        beat(1'b0, kb);
        beat(1'b0, kc);
        in_valid = 1'b0;
        #1;
        chk("keys_abc", 256'(keys), 256'({kc, kb, ka}));
        chk("kv_after_c", 256'(keys_valid), 256'(1'b1));
        tick();

        // Rekey with three results pending.
        core_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_out = {$urandom, $urandom};
            tick();
        end
        core_out_valid = 1'b0;
        core_idle      = 1'b0;
        in_valid       = 1'b1;
        key_config     = 1'b1;
        data_in        = 64'hD4D4_0000_0000_000D;
        tick();
        #1;
        chk("rekey_hold", 256'(rdy), 256'(1'b0));
        tick();
        tick();
        out_rcvd  = 1'b1;
        core_idle = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_rcvd = 1'b0;
        beat(1'b0, 64'hE5E5_0000_0000_000E);
        beat(1'b0, 64'hF6F6_0000_0000_000F);
        in_valid = 1'b0;
        tick();

        // Abort on the second key beat.
        beat(1'b1, 64'h1111);
        beat(1'b1, 64'h2222);
        beat(1'b1, 64'h3333);
        in_valid = 1'b0;
        #1;
        chk("abort_word", 256'(data_out), 256'(64'hE3));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Data before keys.
        beat(1'b0, 64'h1234);
        in_valid = 1'b0;
        #1;
        chk("nokey_word", 256'(data_out), 256'(64'hE1));
        chk("nokey_rdy",  256'(rdy),      256'(1'b0));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        chk("clr_out_valid", 256'(out_valid), 256'(1'b0));

        // Overflow: fill the FIFO, then push with and without a pop.
        beat(1'b1, 64'h4444);
        beat(1'b0, 64'h5555);
        beat(1'b0, 64'h6666);
        in_valid       = 1'b0;
        core_out_valid = 1'b1;
        for (int i = 0; i < DP; i++) begin
            core_out = {$urandom, $urandom};
            tick();
        end
        #1;
        chk("full_stall", 256'(core_stall), 256'(1'b1));
        out_rcvd = 1'b1;
        core_out = {$urandom, $urandom};
        tick();
        #1;
        chk("full_pushpop_noerr", 256'(error), 256'(1'b0));
        out_rcvd = 1'b0;
        core_out = {$urandom, $urandom};
        tick();
        core_out_valid = 1'b0;
        #1;
        chk("overflow_word", 256'(data_out), 256'(64'hE2));
        err_clr = 1'b1;
        tick();
        quiet();

        // Randomised traffic at several backpressure levels.
        for (int i = 0; i < 600; i++) begin rand_inputs(50, 40); tick(); end
        for (int i = 0; i < 600; i++) begin rand_inputs(20, 60); tick(); end
        for (int i = 0; i < 600; i++) begin rand_inputs(85, 30); tick(); end

        // Asynchronous reset in the middle of a key load.
        quiet();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        beat(1'b1, 64'h7777);
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_keys", 256'(keys), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
